// File: rtl/mini_core_mem_arb_if.sv
// Request/response bundle between the mini_core fetch/data requesters, the
// memory arbiter and the unified single-port memory.
interface mini_core_mem_arb_if;
  logic        IReqValid;
  logic [31:0] IReqAddr;
  logic        IReqReady;
  logic        IRspValid;
  logic [31:0] IRspData;

  logic        DReqValid;
  logic        DReqWrEn;
  logic [31:0] DReqAddr;
  logic [31:0] DReqWrData;
  logic [3:0]  DReqByteEn;
  logic        DReqReady;
  logic        DRspValid;
  logic [31:0] DRspData;

  logic        MemReqValid;
  logic        MemWrEn;
  logic [31:0] MemAddr;
  logic [31:0] MemWrData;
  logic [3:0]  MemByteEn;
  logic        MemReady;
  logic [31:0] MemRspData;

  // Arbiter view
  modport slave (
    input  IReqValid, IReqAddr, DReqValid, DReqWrEn, DReqAddr, DReqWrData, DReqByteEn,
           MemReady, MemRspData,
    output IReqReady, IRspValid, IRspData, DReqReady, DRspValid, DRspData,
           MemReqValid, MemWrEn, MemAddr, MemWrData, MemByteEn
  );

  // Environment view (requesters plus memory)
  modport master (
    output IReqValid, IReqAddr, DReqValid, DReqWrEn, DReqAddr, DReqWrData, DReqByteEn,
           MemReady, MemRspData,
    input  IReqReady, IRspValid, IRspData, DReqReady, DRspValid, DRspData,
           MemReqValid, MemWrEn, MemAddr, MemWrData, MemByteEn
  );
endinterface

// File: rtl/mini_core_mem_arb.sv
// Arbitrates the fetch and data requesters onto one single-port memory and
// routes fixed-latency read responses back to the issuing requester.
module mini_core_mem_arb #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                Clock,
  input logic                Rst,
  mini_core_mem_arb_if.slave bus
);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_ARB, S_HOLD_D, S_HOLD_I} arbStateT;

  arbStateT              state;
  logic [STARVE_W-1:0]   starveCnt;
  logic [RD_LATENCY-1:0] tagVld;
  logic [RD_LATENCY-1:0] tagSrc;   // 1 = data requester, 0 = fetch
  logic                  grantD;
  logic                  grantI;
  logic                  reqValid;
  logic                  accept;
  logic                  iReady;
  logic                  wrEn;

  // Grant: held source wins outright; otherwise data first unless fetch is starved
  always_comb begin
    grantD = 1'b0;
    grantI = 1'b0;
    unique case (state)
      S_HOLD_D: grantD = 1'b1;
      S_HOLD_I: grantI = 1'b1;
      default: begin
        if (bus.DReqValid && ((starveCnt < STARVE_W'(STARVE_MAX)) || !bus.IReqValid))
          grantD = 1'b1;
        else if (bus.IReqValid)
          grantI = 1'b1;
      end
    endcase
  end

  assign reqValid = (grantD & bus.DReqValid) | (grantI & bus.IReqValid);
  assign accept   = reqValid & bus.MemReady;
  assign iReady   = grantI & bus.MemReady;
  assign wrEn     = grantD & bus.DReqWrEn;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state     <= S_ARB;
      starveCnt <= '0;
      tagVld    <= '0;
      tagSrc    <= '0;
    end else begin
      unique case (state)
        S_ARB: begin
          if (reqValid && !bus.MemReady)
            state <= grantD ? S_HOLD_D : S_HOLD_I;
        end
        default: begin
          if (accept || !reqValid)
            state <= S_ARB;
        end
      endcase

      if (iReady)
        starveCnt <= '0;
      else if (bus.IReqValid && (starveCnt < STARVE_W'(STARVE_MAX)))
        starveCnt <= starveCnt + STARVE_W'(1);

      // Response tags shift every cycle; memory responses are never stalled
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        tagVld[i] <= tagVld[i-1];
        tagSrc[i] <= tagSrc[i-1];
      end
      tagVld[0] <= accept & ~wrEn;
      tagSrc[0] <= grantD;
    end
  end

  // Every output is held at zero while reset is asserted
  assign bus.IReqReady   = ~Rst & iReady;
  assign bus.DReqReady   = ~Rst & grantD & bus.MemReady;
  assign bus.MemReqValid = ~Rst & reqValid;
  assign bus.MemWrEn     = ~Rst & wrEn;
  assign bus.MemAddr     = Rst ? 32'h0 : (grantD ? bus.DReqAddr : bus.IReqAddr);
  assign bus.MemWrData   = (Rst || !grantD) ? 32'h0 : bus.DReqWrData;
  assign bus.MemByteEn   = Rst ? 4'h0 : (grantD ? bus.DReqByteEn : 4'hF);

  assign bus.IRspValid = ~Rst & tagVld[RD_LATENCY-1] & ~tagSrc[RD_LATENCY-1];
  assign bus.DRspValid = ~Rst & tagVld[RD_LATENCY-1] &  tagSrc[RD_LATENCY-1];
  assign bus.IRspData  = Rst ? 32'h0 : bus.MemRspData;
  assign bus.DRspData  = Rst ? 32'h0 : bus.MemRspData;
endmodule

// File: doc/mini_core_mem_arb.md
Name: mini_core_mem_arb

Overview:
- Shares one single-port unified memory between the mini_core instruction-fetch requester and data-memory requester.
- Sits between the core's fetch/memory-access stages and the memory. Arbitrates per cycle, holds a grant stable while the memory back-pressures, and routes fixed-latency read responses to the issuing requester.
- Data requests have priority, since they come from the later pipeline stage. A starvation counter guarantees fetch progress.

Parameters:
- RD_LATENCY, 1, cycles from an accepted memory read to valid MemRspData (legal range 1..4).
- STARVE_MAX, 4, consecutive un-granted fetch-request cycles after which fetch wins arbitration (legal range >= 1).

Ports:
- Clock  in  1  single clock; all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- IReqValid  in  1  fetch read request.
- IReqAddr  in  32  fetch address.
- IReqReady  out  1  fetch request accepted this cycle.
- IRspValid  out  1  fetch read data valid.
- IRspData  out  32  fetch read data.
- DReqValid  in  1  data request.
- DReqWrEn  in  1  1=store, 0=load.
- DReqAddr  in  32  data address.
- DReqWrData  in  32  store data.
- DReqByteEn  in  4  store byte enables.
- DReqReady  out  1  data request accepted this cycle.
- DRspValid  out  1  load data valid.
- DRspData  out  32  load data.
- MemReqValid  out  1  request to memory.
- MemWrEn  out  1  write strobe.
- MemAddr  out  32  memory address.
- MemWrData  out  32  write data.
- MemByteEn  out  4  byte enables; 4'hF for fetch.
- MemReady  in  1  memory accepts request this cycle.
- MemRspData  in  32  read data, RD_LATENCY cycles after acceptance.

Behaviour:
- Handshakes:
  - Requester handshake: valid/ready. A requester holds valid and payload stable until its Ready is high.
  - IReqReady = grant_I & MemReady; DReqReady = grant_D & MemReady. Both are combinational.
  - Memory accepts a request when MemReqValid & MemReady.
- Request mux: MemReqValid = IReqValid | DReqValid, gated by the hold state. The Mem* payload is a mux of the granted source. Fetch drives MemWrEn=0, MemWrData=0, MemByteEn=4'hF.
- Grant FSM:
  - S_ARB:
    - Grant D if DReqValid and (starve_cnt < STARVE_MAX or !IReqValid); otherwise grant I if IReqValid.
    - If the granted request is not accepted (MemReady=0), go to S_HOLD_D or S_HOLD_I.
  - S_HOLD_D / S_HOLD_I:
    - Grant is fixed to the held source regardless of the other requester.
    - On acceptance, return to S_ARB. The next arbitration occurs in the following cycle.
- Starvation counter (width $clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, each cycle IReqValid=1 and IReqReady=0.
  - Clears on IReqReady.
  - Holds when IReqValid=0.
- Response tracking:
  - Shift pipeline of RD_LATENCY entries {vld, src}. It shifts every cycle unconditionally; responses are never back-pressured.
  - Stage 0 is loaded with vld = accepted read (write accepted -> vld=0), src = granted source.
  - At the last stage: IRspValid = vld & src==I; DRspValid = vld & src==D.
  - IRspData and DRspData = MemRspData continuously; the Valid outputs qualify the data.
- No responses for writes. Reads and writes may be accepted back-to-back, one per cycle.
- Reset (async assert, sync release):
  - FSM -> S_ARB, starve_cnt=0, all tag entries cleared.
  - While Rst=1, all outputs are forced to 0.
  - Reads in flight at reset are dropped: no response after release.
- Simultaneous events:
  - Both valid in S_ARB with starve_cnt < STARVE_MAX: D wins.
  - Both valid with starve_cnt == STARVE_MAX: I wins.
  - Request acceptance and a response retiring in the same cycle are independent.
- Invariants:
  - At most one of IReqReady/DReqReady high per cycle.
  - At most one of IRspValid/DRspValid high per cycle.
  - Grant never changes while MemReqValid=1 and MemReady=0.

Test Plan:
- Fetch-only read: IReqValid=1, IReqAddr=0x100, MemReady=1, RD_LATENCY=1. Expected: IReqReady=1 in the same cycle, MemAddr=0x100, MemByteEn=4'hF. Next cycle IRspValid=1 and IRspData=MemRspData (0xDEADBEEF); DRspValid stays 0.
- Simultaneous reads: I addr 0x10 and D addr 0x2000, both valid, MemReady=1. Expected: cycle 0 DReqReady=1 with MemAddr=0x2000; cycle 1 IReqReady=1 with MemAddr=0x10. Responses arrive as DRspValid then IRspValid on consecutive cycles.
- Starvation: STARVE_MAX=4, D valid continuously, I valid from cycle 0. Expected: D is granted cycles 0-3 (starve_cnt reaches 4), I is granted in cycle 4, and starve_cnt returns to 0.
- Back-pressure hold: D read granted with MemReady=0 for 3 cycles; I becomes valid in cycle 1. Expected: MemAddr and payload stay on D, and IReqReady=0 throughout. D is accepted when MemReady=1, and I is granted the next cycle.
- Store: DReqWrEn=1, addr 0x3004, data 0x12345678, ByteEn 4'b0011. Expected: MemWrEn=1 and all fields passed through unchanged; DRspValid stays 0 for RD_LATENCY+2 cycles.
- Reset mid-flight: RD_LATENCY=2, D read accepted, Rst asserted the next cycle for 1 cycle. Expected: all outputs are 0 during Rst, and no DRspValid occurs after release.
